// File: rtl/clk_div_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_div_ctrl_pkg : shared types and defaults for the clock-enable divider |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    localparam int CNT_W_DFLT   = 8;
    localparam int DEF_DIV_DFLT = 3;
    localparam int TICKCNT_W    = 16;

endpackage
`default_nettype wire

// File: rtl/clk_div_ctrl_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_div_ctrl_cnt : period counter, wrap decode, tick and square enable    |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module clk_div_ctrl_cnt
    import clk_div_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DFLT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_i,
    input  logic [CNT_W-1:0] div_cur_i,
    output logic             wrap_o,
    output logic             tick_o,
    output logic             sq_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   half_w;

    // Extra bit keeps (div+1)>>1 exact at the largest divisor.
    assign half_w = ({1'b0, div_cur_i} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

    assign wrap_o = run_i && (cnt_q == (div_cur_i - {{(CNT_W-1){1'b0}}, 1'b1}));
    assign tick_o = run_i && (cnt_q == '0);
    assign sq_o   = run_i && ({1'b0, cnt_q} < half_w);

    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (!run_i || wrap_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_div_ctrl : programmable tick/square enable divider with config port   |
// | Option macro CLK_DIV_CTRL_TICKCNT_EN adds the tick_cnt output.            |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DFLT,
    parameter int DEF_DIV = DEF_DIV_DFLT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 cfg_valid,
    input  logic [CNT_W-1:0]     cfg_div,
    output logic                 cfg_ready,
    output logic                 cfg_err,
    output logic                 tick,
    output logic                 sq,
    output logic                 busy,
    output logic [CNT_W-1:0]     div_cur
`ifdef CLK_DIV_CTRL_TICKCNT_EN
    ,
    output logic [TICKCNT_W-1:0] tick_cnt
`endif
);

    localparam logic [CNT_W-1:0] DEF_DIV_L = CNT_W'(DEF_DIV);

    ctrl_state_t      state_q;
    logic [CNT_W-1:0] div_cur_q;
    logic [CNT_W-1:0] div_cur_d;
    logic [CNT_W-1:0] shadow_q;
    logic [CNT_W-1:0] shadow_d;
    logic             shadow_full_q;
    logic             shadow_full_d;
    logic             cfg_err_q;
    logic             run;
    logic             wrap;
    logic             cfg_acc;
    logic             cfg_legal;

    assign run       = (state_q != IDLE);
    assign busy      = run;
    assign cfg_ready = !run || !shadow_full_q;
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign cfg_legal = (cfg_div != '0);
    assign cfg_err   = cfg_err_q;
    assign div_cur   = div_cur_q;

    // While counting, divisor changes only land on a wrap so no period is cut short.
    always_comb begin
        div_cur_d     = div_cur_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        if (!run) begin
            if (cfg_acc && cfg_legal) begin
                div_cur_d = cfg_div;
            end
        end else if (wrap) begin
            if (shadow_full_q) begin
                div_cur_d     = shadow_q;
                shadow_full_d = 1'b0;
            end else if (cfg_acc && cfg_legal) begin
                div_cur_d = cfg_div;
            end
        end else if (cfg_acc && cfg_legal) begin
            shadow_d      = cfg_div;
            shadow_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            div_cur_q     <= DEF_DIV_L;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            div_cur_q     <= div_cur_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            cfg_err_q     <= cfg_acc && !cfg_legal;
            case (state_q)
                IDLE:    if (en) state_q <= RUN;
                RUN:     if (!en) state_q <= DRAIN;
                DRAIN: begin
                    if (en) begin
                        state_q <= RUN;
                    end else if (wrap) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    clk_div_ctrl_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .run_i     (run),
        .div_cur_i (div_cur_q),
        .wrap_o    (wrap),
        .tick_o    (tick),
        .sq_o      (sq)
    );

`ifdef CLK_DIV_CTRL_TICKCNT_EN
    logic [TICKCNT_W-1:0] tick_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if ((state_q == IDLE) && en) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + {{(TICKCNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick_cnt = tick_cnt_q;
`endif

endmodule
`default_nettype wire
